// File: rtl/ebus_pkg.sv
// Shared EBUS definitions: function codes, arbiter state encoding and the
// write-function helper used by the transfer arbiter.
package ebus_pkg;

    typedef enum logic [2:0] {
        FN_CONO    = 3'd0,
        FN_CONI    = 3'd1,
        FN_DATAO   = 3'd2,
        FN_DATAI   = 3'd3,
        FN_PI_SERV = 3'd4,
        FN_PI_FUNC = 3'd5
    } ebus_func_e;

    typedef logic [2:0] arb_state_t;

    localparam arb_state_t ST_IDLE   = 3'd0;
    localparam arb_state_t ST_SETUP  = 3'd1;
    localparam arb_state_t ST_DEMAND = 3'd2;
    localparam arb_state_t ST_HOLD   = 3'd3;
    localparam arb_state_t ST_REL    = 3'd4;

    function automatic logic is_write(input logic [2:0] fn);
        return (fn == 3'(FN_CONO)) || (fn == 3'(FN_DATAO));
    endfunction

endpackage

// File: rtl/ebus_sync.sv
// Two-flop synchronizer for the device transfer acknowledge.
module ebus_sync (
    input  logic clk_con_h,
    input  logic mr_reset_l,
    input  logic d,
    output logic q
);

    logic meta_q;

    always_ff @(posedge clk_con_h or negedge mr_reset_l) begin
        if (!mr_reset_l) begin
            meta_q <= 1'b0;
            q      <= 1'b0;
        end else begin
            meta_q <= d;
            q      <= meta_q;
        end
    end

endmodule

// File: rtl/ebus_xfer_arb.sv
// EBUS master: arbitrates EBOX I/O and PI function cycles and sequences each
// transfer through setup, demand, acknowledge hold and release.
//
// state  | meaning
// IDLE   | bus free, arbitrate pending requests
// SETUP  | cs/func/data driven, waiting before demand
// DEMAND | demand asserted, waiting for synchronized xfer
// HOLD   | demand dropped, waiting for xfer to deassert
// REL    | bus released, dead time before next grant
module ebus_xfer_arb
    import ebus_pkg::*;
#(
    parameter int DATA_W      = 36,
    parameter int CS_W        = 7,
    parameter int SETUP_CYC   = 2,
    parameter int TIMEOUT_CYC = 255,
    parameter int DEAD_CYC    = 1
) (
    input  logic              clk_con_h,
    input  logic              mr_reset_l,
    input  logic              ebox_req_h,
    input  logic [2:0]        ebox_func_h,
    input  logic [CS_W-1:0]   ebox_cs_h,
    input  logic [DATA_W-1:0] ebox_data_h,
    output logic              ebox_done_h,
    output logic              ebox_timeout_h,
    output logic [DATA_W-1:0] ebox_rdata_h,
    input  logic              pi_req_h,
    input  logic [2:0]        pi_func_h,
    input  logic [CS_W-1:0]   pi_cs_h,
    output logic              pi_grant_h,
    output logic              pi_done_h,
    output logic              pi_timeout_h,
    output logic [CS_W-1:0]   ebus_cs_h,
    output logic [2:0]        ebus_func_h,
    output logic              ebus_demand_h,
    output logic              ebus_d_oe_h,
    output logic [DATA_W-1:0] ebus_d_out_h,
    input  logic [DATA_W-1:0] ebus_d_in_h,
    input  logic              ebus_xfer_h,
    output logic              ebus_busy_h
);

    localparam int              TMR_W      = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TMR_W-1:0] SETUP_LOAD = TMR_W'(SETUP_CYC - 1);
    localparam logic [TMR_W-1:0] TMO_LOAD   = TMR_W'(TIMEOUT_CYC - 1);
    localparam logic [TMR_W-1:0] DEAD_LOAD  = TMR_W'((DEAD_CYC > 0) ? DEAD_CYC - 1 : 0);

    arb_state_t       state_q;
    logic [TMR_W-1:0] timer_q;
    logic             pi_owner_q;
    logic             ptr_pi_q;
    logic             xfer_s;
    logic             end_ok;
    logic             end_to;
    logic             arb_en;
    logic             grant_pi;

    ebus_sync u_xfer_sync (
        .clk_con_h  (clk_con_h),
        .mr_reset_l (mr_reset_l),
        .d          (ebus_xfer_h),
        .q          (xfer_s)
    );

    // With no dead time the last release cycle doubles as the arbitration cycle.
    assign arb_en   = (state_q == ST_IDLE) ||
                      ((DEAD_CYC == 0) && (state_q == ST_REL) && (timer_q == '0));
    assign grant_pi = pi_req_h && (!ebox_req_h || ptr_pi_q);

    always_comb begin
        end_ok = 1'b0;
        end_to = 1'b0;
        case (state_q)
            ST_DEMAND: end_to = !xfer_s && (timer_q == '0);
            ST_HOLD: begin
                end_ok = !xfer_s;
                end_to = xfer_s && (timer_q == '0);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_con_h or negedge mr_reset_l) begin
        if (!mr_reset_l) begin
            state_q        <= ST_IDLE;
            timer_q        <= '0;
            pi_owner_q     <= 1'b0;
            ptr_pi_q       <= 1'b1;
            ebus_cs_h      <= '0;
            ebus_func_h    <= '0;
            ebus_d_out_h   <= '0;
            ebox_rdata_h   <= '0;
            ebox_done_h    <= 1'b0;
            ebox_timeout_h <= 1'b0;
            pi_done_h      <= 1'b0;
            pi_timeout_h   <= 1'b0;
        end else begin
            ebox_done_h    <= end_ok && !pi_owner_q;
            ebox_timeout_h <= end_to && !pi_owner_q;
            pi_done_h      <= (end_ok || end_to) && pi_owner_q;
            pi_timeout_h   <= end_to && pi_owner_q;

            if (end_ok || end_to) begin
                state_q     <= ST_REL;
                timer_q     <= DEAD_LOAD;
                ebus_cs_h   <= '0;
                ebus_func_h <= '0;
            end else if (arb_en && (pi_req_h || ebox_req_h)) begin
                state_q      <= ST_SETUP;
                timer_q      <= SETUP_LOAD;
                pi_owner_q   <= grant_pi;
                ptr_pi_q     <= !grant_pi;
                ebus_cs_h    <= grant_pi ? pi_cs_h : ebox_cs_h;
                ebus_func_h  <= grant_pi ? pi_func_h : ebox_func_h;
                ebus_d_out_h <= grant_pi ? '0 : ebox_data_h;
            end else begin
                case (state_q)
                    ST_IDLE: ;
                    ST_SETUP: begin
                        if (timer_q == '0) begin
                            state_q <= ST_DEMAND;
                            timer_q <= TMO_LOAD;
                        end else begin
                            timer_q <= timer_q - TMR_W'(1);
                        end
                    end
                    ST_DEMAND: begin
                        if (xfer_s) begin
                            if (!pi_owner_q && !is_write(ebus_func_h))
                                ebox_rdata_h <= ebus_d_in_h;
                            state_q <= ST_HOLD;
                            timer_q <= TMO_LOAD;
                        end else begin
                            timer_q <= timer_q - TMR_W'(1);
                        end
                    end
                    ST_HOLD: timer_q <= timer_q - TMR_W'(1);
                    ST_REL: begin
                        if (timer_q == '0)
                            state_q <= ST_IDLE;
                        else
                            timer_q <= timer_q - TMR_W'(1);
                    end
                    default: state_q <= ST_IDLE;
                endcase
            end
        end
    end

    assign ebus_demand_h = (state_q == ST_DEMAND);
    assign ebus_busy_h   = (state_q != ST_IDLE);
    assign pi_grant_h    = pi_owner_q && ebus_busy_h;
    // func is cleared to CONO in REL, so the state qualifier keeps oe low there.
    assign ebus_d_oe_h   = is_write(ebus_func_h) &&
                           ((state_q == ST_SETUP) || (state_q == ST_DEMAND) || (state_q == ST_HOLD));

endmodule
